multiply_accumulate: RTL

Streaming accumulator that sits directly downstream of the hard `multiply` black-box. It consumes one product per cycle over a valid/ready handshake and sums the products of a frame delimited by `p_last`. It presents the frame total, beat count and overflow flag on an output handshake, holding them until accepted. Together with `multiply` it forms the MAC datapath that yosys maps onto VPR hard multipliers plus soft accumulation logic.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/sat_add.sv | 38 +++
 rtl/multiply_accumulate.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and clamp constants for the soft MAC accumulation stages.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

  // Widest accumulator the clamp helpers can describe.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] acc_max(input int width, input bit sgn);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - (sgn ? 1 : 0)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] acc_min(input int width, input bit sgn);
    logic [MAX_W-1:0] v;
    v = '0;
    if (sgn) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational WIDTH-bit adder with overflow detection and optional clamp.
module sat_add
  import mac_pkg::*;
#(
  parameter int WIDTH    = 80,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [MAX_W-1:0] MAX_FULL = acc_max(WIDTH, SIGNED != 0);
  localparam logic [MAX_W-1:0] MIN_FULL = acc_min(WIDTH, SIGNED != 0);
  localparam logic [WIDTH-1:0] MAX_V    = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V    = MIN_FULL[WIDTH-1:0];

  logic [WIDTH:0] raw;

  assign raw = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    sum_o = raw[WIDTH-1:0];
    ovf_o = 1'b0;
    if (SIGNED != 0) begin
      ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      ovf_o = raw[WIDTH];
    end
    // Signed overflow direction follows the common operand sign.
    if (ovf_o && (SATURATE != 0)) begin
      sum_o = ((SIGNED != 0) && a_i[WIDTH-1]) ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/multiply_accumulate.sv
// Streaming frame accumulator behind the hard multiplier: sums products of a
// p_last-delimited frame and holds total, beat count and overflow until taken.
module multiply_accumulate
  import mac_pkg::*;
#(
  parameter int P_WIDTH   = 72,
  parameter int ACC_WIDTH = 80,
  parameter int CNT_WIDTH = 16,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic [P_WIDTH-1:0]   p_data,
  input  logic                 p_last,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic [CNT_WIDTH-1:0] acc_count,
  output logic                 acc_ovf
);

  mac_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 aovf_q, aovf_d;

  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] base_sum;
  logic [CNT_WIDTH-1:0] base_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 base_ovf;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic                 accept;
  logic                 xfer;

  generate
    if (ACC_WIDTH == P_WIDTH) begin : g_ext_none
      assign p_ext = p_data;
    end else if (SIGNED != 0) begin : g_ext_sign
      assign p_ext = {{(ACC_WIDTH-P_WIDTH){p_data[P_WIDTH-1]}}, p_data};
    end else begin : g_ext_zero
      assign p_ext = {{(ACC_WIDTH-P_WIDTH){1'b0}}, p_data};
    end
  endgenerate

  assign acc_valid = (state_q == HOLD);
  assign p_ready   = (state_q == ACCUM) || acc_ready;
  assign acc_data  = data_q;
  assign acc_count = count_q;
  assign acc_ovf   = aovf_q;

  assign accept = p_valid && p_ready;
  assign xfer   = acc_valid && acc_ready;

  // A beat accepted while a result is held always opens a fresh frame.
  assign base_sum = (state_q == HOLD) ? '0 : sum_q;
  assign base_cnt = (state_q == HOLD) ? '0 : cnt_q;
  assign base_ovf = (state_q == HOLD) ? 1'b0 : ovf_q;
  assign cnt_inc  = (base_cnt == '1) ? base_cnt : base_cnt + CNT_WIDTH'(1);

  sat_add #(
    .WIDTH   (ACC_WIDTH),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_add (
    .a_i  (base_sum),
    .b_i  (p_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    count_d = count_q;
    aovf_d  = aovf_q;
    if (accept) begin
      if (p_last) begin
        data_d  = add_sum;
        count_d = cnt_inc;
        aovf_d  = base_ovf | add_ovf;
        sum_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = HOLD;
      end else begin
        sum_d   = add_sum;
        cnt_d   = cnt_inc;
        ovf_d   = base_ovf | add_ovf;
        state_d = ACCUM;
      end
    end else if (xfer) begin
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      aovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      count_q <= count_d;
      aovf_q  <= aovf_d;
    end
  end

endmodule
